// File: rtl/seq_num_gen_l2.sv
// Fetch-stage sequence-number allocator: hands out numbers in order and
// reclaims them oldest-first, up to p_reclaim_width per cycle, once committed.
module seq_num_gen_l2 #(
  parameter int p_seq_num_bits  = 5,
  parameter int p_reclaim_width = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  output logic                      alloc_val,
  input  logic                      alloc_rdy,
  input  logic                      commit_val,
  input  logic [p_seq_num_bits-1:0] commit_seq_num,
  input  logic [31:0]               commit_pc,
  input  logic [4:0]                commit_waddr,
  input  logic [31:0]               commit_wdata,
  input  logic                      commit_wen
);

  localparam int N  = 1 << p_seq_num_bits;
  localparam int KW = $clog2(p_reclaim_width + 1);

  typedef logic [p_seq_num_bits-1:0] seq_t;
  typedef logic [p_seq_num_bits:0]   cnt_t;

  seq_t         head_q, head_d;
  seq_t         tail_q, tail_d;
  logic [N-1:0] alloc_q, alloc_d;
  logic [N-1:0] done_q, done_d;
  cnt_t         entries_allocated, entries_allocated_d;

  logic          fire;
  logic [KW-1:0] reclaim_k;
  logic [N-1:0]  reclaim_mask;
  seq_t          scan_idx;
  logic          scan_run;

  logic unused_commit_fields;
  assign unused_commit_fields = ^{commit_pc, commit_waddr, commit_wdata, commit_wen};

  assign alloc_seq_num = head_q;
  assign alloc_val     = (entries_allocated != cnt_t'(N));
  assign fire          = alloc_val & alloc_rdy;

  // Walk from tail; the first entry that is not allocated-and-done ends the run.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    reclaim_k    = '0;
    reclaim_mask = '0;
    scan_idx     = tail_q;
    scan_run     = 1'b1;
    for (int i = 0; i < p_reclaim_width; i++) begin
      scan_idx = tail_q + seq_t'(i);
      scan_run = scan_run & alloc_q[scan_idx] & done_q[scan_idx];
      if (scan_run) begin
        reclaim_mask[scan_idx] = 1'b1;
        reclaim_k              = reclaim_k + KW'(1);
      end
    end
  end

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (commit_val && alloc_q[commit_seq_num]) begin
      done_d[commit_seq_num] = 1'b1;
    end
    // Clear after the commit update so a late duplicate commit cannot resurrect a reclaimed slot.
    alloc_d = alloc_d & ~reclaim_mask;
    done_d  = done_d  & ~reclaim_mask;
    if (fire) begin
      alloc_d[head_q] = 1'b1;
    end
    head_d              = head_q + seq_t'(fire);
    tail_d              = tail_q + seq_t'(reclaim_k);
    entries_allocated_d = entries_allocated + cnt_t'(fire) - cnt_t'(reclaim_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the alloc/done vectors must be reset, since reclaim reads them directly.
      head_q            <= '0;
      tail_q            <= '0;
      alloc_q           <= '0;
      done_q            <= '0;
      entries_allocated <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      head_q            <= head_d;
      tail_q            <= tail_d;
      alloc_q           <= alloc_d;
      done_q            <= done_d;
      entries_allocated <= entries_allocated_d;
    end
  end

  // Level 1: allocated number (3 chars); level 2 adds reclaim count (4 chars).
  function automatic string trace(int level);
    string s;
    s = "";
    if (level >= 1) begin
      s = fire ? $sformatf("%3d", int'(head_q)) : "   ";
    end
    if (level >= 2) begin
      s = {s, $sformatf("|-%2d", int'(reclaim_k))};
    end
    return s;
  endfunction

endmodule

// File: tb/tb_seq_num_gen_l2.sv
// Directed bench for seq_num_gen_l2: three instances (5/2, 6/2, 8/8 bits/width)
// driven one at a time with hand-computed expected values.
module tb_seq_num_gen_l2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy  [3];
  logic       cval [3];
  logic [7:0] cseq [3];

  logic [4:0] seq5;
  logic [5:0] seq6;
  logic [7:0] seq8;
  logic       val5, val6, val8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_num_gen_l2 #(.p_seq_num_bits(5), .p_reclaim_width(2)) u5 (
    .clk(clk), .rst(rst),
    .alloc_seq_num(seq5), .alloc_val(val5), .alloc_rdy(rdy[0]),
    .commit_val(cval[0]), .commit_seq_num(cseq[0][4:0]),
    .commit_pc(32'h0), .commit_waddr(5'h0), .commit_wdata(32'h0), .commit_wen(1'b0)
  );

  seq_num_gen_l2 #(.p_seq_num_bits(6), .p_reclaim_width(2)) u6 (
    .clk(clk), .rst(rst),
    .alloc_seq_num(seq6), .alloc_val(val6), .alloc_rdy(rdy[1]),
    .commit_val(cval[1]), .commit_seq_num(cseq[1][5:0]),
    .commit_pc(32'h0), .commit_waddr(5'h0), .commit_wdata(32'h0), .commit_wen(1'b0)
  );

  seq_num_gen_l2 #(.p_seq_num_bits(8), .p_reclaim_width(8)) u8 (
    .clk(clk), .rst(rst),
    .alloc_seq_num(seq8), .alloc_val(val8), .alloc_rdy(rdy[2]),
    .commit_val(cval[2]), .commit_seq_num(cseq[2]),
    .commit_pc(32'h0), .commit_waddr(5'h0), .commit_wdata(32'h0), .commit_wen(1'b0)
  );

  function automatic int get_seq(int d);
    case (d)
      0:       return int'(seq5);
      1:       return int'(seq6);
      default: return int'(seq8);
    endcase
  endfunction

  function automatic int get_val(int d);
    case (d)
      0:       return int'(val5);
      1:       return int'(val6);
      default: return int'(val8);
    endcase
  endfunction

  function automatic int get_cnt(int d);
    case (d)
      0:       return int'(u5.entries_allocated);
      1:       return int'(u6.entries_allocated);
      default: return int'(u8.entries_allocated);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      rdy[d]  = 1'b0;
      cval[d] = 1'b0;
      cseq[d] = 8'd0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first four allocations.
    do_reset();
    check("rst_cnt", get_cnt(0), 0);
    check("rst_val", get_val(0), 1);
    check("rst_seq", get_seq(0), 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_seq", get_seq(0), i);
      rdy[0] = 1'b1;
      tick();
    end
    rdy[0] = 1'b0;
    check("t1_cnt", get_cnt(0), 4);

    // Fill the pool, hold while full, then one reclaim reopens it at number 0.
    for (int i = 4; i < 32; i++) begin
      check("t2_seq", get_seq(0), i);
      rdy[0] = 1'b1;
      tick();
    end
    rdy[0] = 1'b0;
    check("t2_full_val", get_val(0), 0);
    check("t2_full_cnt", get_cnt(0), 32);
    check("t2_wrap_seq", get_seq(0), 0);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check("t2_full_hold", get_cnt(0), 32);
    cval[0] = 1'b1;
    cseq[0] = 8'd0;
    tick();
    cval[0] = 1'b0;
    check("t2_commit_lat_cnt", get_cnt(0), 32);
    check("t2_commit_lat_val", get_val(0), 0);
    tick();
    check("t2_reclaim_cnt", get_cnt(0), 31);
    check("t2_reclaim_val", get_val(0), 1);
    check("t2_reclaim_seq", get_seq(0), 0);

    // Reset mid-operation.
    do_reset();
    check("mid_rst_cnt", get_cnt(0), 0);
    check("mid_rst_val", get_val(0), 1);
    check("mid_rst_seq", get_seq(0), 0);

    // Out-of-order commits: oldest uncommitted entry blocks reclaim.
    rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rdy[0] = 1'b0;
    for (int s = 3; s >= 1; s--) begin
      cval[0] = 1'b1;
      cseq[0] = 8'(s);
      tick();
      check("t3_blocked_cnt", get_cnt(0), 4);
    end
    cval[0] = 1'b0;
    tick();
    check("t3_blocked_idle", get_cnt(0), 4);
    cval[0] = 1'b1;
    cseq[0] = 8'd0;
    tick();
    cval[0] = 1'b0;
    check("t3_drain0", get_cnt(0), 4);
    tick();
    check("t3_drain1", get_cnt(0), 2);
    tick();
    check("t3_drain2", get_cnt(0), 0);
    check("t3_empty_val", get_val(0), 1);
    check("t3_empty_seq", get_seq(0), 4);

    // Commit to an unallocated number is ignored.
    cval[0] = 1'b1;
    cseq[0] = 8'd5;
    tick();
    cval[0] = 1'b0;
    rdy[0]  = 1'b1;
    tick();
    tick();
    rdy[0]  = 1'b0;
    check("t3_unalloc_cnt", get_cnt(0), 2);
    cval[0] = 1'b1;
    cseq[0] = 8'd4;
    tick();
    cval[0] = 1'b0;
    tick();
    check("t3_unalloc_reclaim", get_cnt(0), 1);
    tick();
    check("t3_unalloc_stays", get_cnt(0), 1);

    // Back-pressure: offer held for three cycles, then sequence resumes.
    for (int j = 0; j < 3; j++) begin
      check("t5_hold_seq", get_seq(0), 6);
      check("t5_hold_val", get_val(0), 1);
      tick();
    end
    check("t5_hold_cnt", get_cnt(0), 1);
    rdy[0] = 1'b1;
    check("t5_resume_seq0", get_seq(0), 6);
    tick();
    check("t5_resume_seq1", get_seq(0), 7);
    tick();
    rdy[0] = 1'b0;
    check("t5_resume_seq2", get_seq(0), 8);
    check("t5_resume_cnt", get_cnt(0), 3);

    // Wide reclaim: commits youngest-first, so committing 0 releases all 8 at once.
    do_reset();
    rdy[2] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rdy[2] = 1'b0;
    check("t4_alloc_cnt", get_cnt(2), 8);
    for (int s = 7; s >= 0; s--) begin
      cval[2] = 1'b1;
      cseq[2] = 8'(s);
      tick();
      check("t4_pending_cnt", get_cnt(2), 8);
    end
    cval[2] = 1'b0;
    tick();
    check("t4_bulk_cnt", get_cnt(2), 0);
    check("t4_bulk_seq", get_seq(2), 8);

    // Streaming: allocate every cycle, commit the number issued two cycles earlier.
    // Number c is allocated at edge c+1 and reclaimed at edge c+4, so count = min(c,3).
    for (int d = 0; d < 3; d++) begin
      int n;
      n = (d == 0) ? 32 : (d == 1) ? 64 : 256;
      do_reset();
      for (int c = 0; c < 3 * n + 3; c++) begin
        check("t6_seq", get_seq(d), c % n);
        check("t6_val", get_val(d), 1);
        check("t6_cnt", get_cnt(d), (c < 3) ? c : 3);
        rdy[d]  = 1'b1;
        cval[d] = (c >= 2);
        cseq[d] = (c >= 2) ? 8'((c - 2) % n) : 8'd0;
        tick();
      end
      idle_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
